rx_dfe_sequencer: RTL and testbench

//  Run-time controller for the RX DFE datapath. Each run has four phases:
//   1. flush the DFE delay line with zero symbols;
//   2. train it for a fixed number of symbols, joining channel symbols with the

---
 rtl/rx_dfe_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_rx_dfe_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_dfe_sequencer.sv
// Run-time sequencer for the RX DFE: flush, joined training, payload streaming
// and drain, with outstanding-result tracking and payload-only result forwarding.
module rx_dfe_sequencer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FLUSH_CYC = 8,
    parameter int unsigned DRAIN_TO  = 64
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  train_len,
    input  logic [CNT_W-1:0]  data_len,
    input  logic [DATA_W-1:0] ch_sym,
    input  logic              ch_sym_valid,
    output logic              ch_sym_ready,
    input  logic [DATA_W-1:0] ref_sym,
    input  logic              ref_sym_valid,
    output logic              ref_sym_ready,
    input  logic [DATA_W-1:0] noise_in,
    output logic [DATA_W-1:0] dfe_signal_in,
    output logic              dfe_signal_in_valid,
    output logic [DATA_W-1:0] dfe_noise,
    output logic [DATA_W-1:0] dfe_train_data,
    output logic              dfe_train_data_valid,
    input  logic [DATA_W-1:0] dfe_signal_out,
    input  logic              dfe_signal_out_valid,
    output logic [DATA_W-1:0] out_sym,
    output logic              out_sym_valid,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    localparam int unsigned      CMP_W      = CNT_W + 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CMP_W-1:0] FLUSH_EXT  = CMP_W'(FLUSH_CYC);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_TRAIN = 3'd2,
        ST_DATA  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   train_len_q, train_len_d;
    logic [CNT_W-1:0]   data_len_q, data_len_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;

    logic [DATA_W-1:0]  sig_d, noise_d, trn_d, out_d;
    logic               sig_vld_d, trn_vld_d, out_vld_d;
    logic               done_d, err_d, busy_d;
    logic               clr_run, res_take, res_keep;
    logic [CMP_W-1:0]   keep_thresh;

    assign state = state_q;

    // Phase sequencing and next values of the registered DFE-side outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        train_len_d   = train_len_q;
        data_len_d    = data_len_q;
        sig_d         = '0;
        sig_vld_d     = 1'b0;
        noise_d       = '0;
        trn_d         = '0;
        trn_vld_d     = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        ch_sym_ready  = 1'b0;
        ref_sym_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    train_len_d = train_len;
                    data_len_d  = data_len;
                    cnt_d       = '0;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                sig_vld_d = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = (train_len_q == '0) ? ST_DATA : ST_TRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_TRAIN: begin
                ch_sym_ready  = ch_sym_valid & ref_sym_valid;
                ref_sym_ready = ch_sym_valid & ref_sym_valid;
                if (ch_sym_valid && ref_sym_valid) begin
                    sig_d     = ch_sym;
                    sig_vld_d = 1'b1;
                    noise_d   = noise_in;
                    trn_d     = ref_sym;
                    trn_vld_d = 1'b1;
                    if (cnt_q == train_len_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DATA: begin
                ch_sym_ready = ch_sym_valid;
                if (ch_sym_valid) begin
                    sig_d     = ch_sym;
                    sig_vld_d = 1'b1;
                    noise_d   = noise_in;
                    // data_len of zero never matches: stream until abort
                    if (data_len_q != '0 && cnt_q == data_len_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // The last issued symbol is counted only once its valid is visible
                if (outst_q == '0 && !dfe_signal_in_valid) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == DRAIN_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            sig_d         = '0;
            sig_vld_d     = 1'b0;
            noise_d       = '0;
            trn_d         = '0;
            trn_vld_d     = 1'b0;
            done_d        = 1'b0;
            err_d         = 1'b0;
            ch_sym_ready  = 1'b0;
            ref_sym_ready = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Outstanding tracking and payload tagging of DFE results
    always_comb begin
        clr_run     = (state_d == ST_IDLE);
        res_take    = dfe_signal_out_valid && (state_q != ST_IDLE) && (outst_q != '0);
        keep_thresh = CMP_W'(train_len_q) + FLUSH_EXT;
        res_keep    = res_take && (CMP_W'(rx_cnt_q) >= keep_thresh);
        out_vld_d   = res_keep && !abort;
        out_d       = out_vld_d ? dfe_signal_out : '0;

        outst_d = outst_q;
        if (clr_run) begin
            outst_d = '0;
        end else if (dfe_signal_in_valid && !res_take) begin
            if (outst_q != CNT_MAX) begin
                outst_d = outst_q + CNT_ONE;
            end
        end else if (!dfe_signal_in_valid && res_take) begin
            outst_d = outst_q - CNT_ONE;
        end

        rx_cnt_d = clr_run ? '0 : (res_take ? rx_cnt_q + CNT_ONE : rx_cnt_q);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q              <= ST_IDLE;
            cnt_q                <= '0;
            train_len_q          <= '0;
            data_len_q           <= '0;
            outst_q              <= '0;
            rx_cnt_q             <= '0;
            dfe_signal_in        <= '0;
            dfe_signal_in_valid  <= 1'b0;
            dfe_noise            <= '0;
            dfe_train_data       <= '0;
            dfe_train_data_valid <= 1'b0;
            out_sym              <= '0;
            out_sym_valid        <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            err_timeout          <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            train_len_q          <= train_len_d;
            data_len_q           <= data_len_d;
            outst_q              <= outst_d;
            rx_cnt_q             <= rx_cnt_d;
            dfe_signal_in        <= sig_d;
            dfe_signal_in_valid  <= sig_vld_d;
            dfe_noise            <= noise_d;
            dfe_train_data       <= trn_d;
            dfe_train_data_valid <= trn_vld_d;
            out_sym              <= out_d;
            out_sym_valid        <= out_vld_d;
            busy                 <= busy_d;
            done                 <= done_d;
            err_timeout          <= err_d;
        end
    end

endmodule

// File: tb/tb_rx_dfe_sequencer.sv
// Scoreboard bench for rx_dfe_sequencer: random symbol streams, a 3-cycle DFE
// model, and expected DFE-input / payload-output queues built per run.
module tb_rx_dfe_sequencer;

    localparam int FLUSH = 8;
    localparam int DTO   = 64;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        start, abort;
    logic [15:0] train_len, data_len;
    logic [7:0]  ch_sym, ref_sym, noise_in;
    logic        ch_sym_valid, ref_sym_valid;
    logic        ch_sym_ready, ref_sym_ready;
    logic [7:0]  dfe_signal_in, dfe_noise, dfe_train_data, dfe_signal_out, out_sym;
    logic        dfe_signal_in_valid, dfe_train_data_valid, dfe_signal_out_valid, out_sym_valid;
    logic [2:0]  state;
    logic        busy, done, err_timeout;

    always #5 clk_clk = ~clk_clk;

    rx_dfe_sequencer dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start), .abort(abort),
        .train_len(train_len), .data_len(data_len),
        .ch_sym(ch_sym), .ch_sym_valid(ch_sym_valid), .ch_sym_ready(ch_sym_ready),
        .ref_sym(ref_sym), .ref_sym_valid(ref_sym_valid), .ref_sym_ready(ref_sym_ready),
        .noise_in(noise_in), .dfe_signal_in(dfe_signal_in),
        .dfe_signal_in_valid(dfe_signal_in_valid), .dfe_noise(dfe_noise),
        .dfe_train_data(dfe_train_data), .dfe_train_data_valid(dfe_train_data_valid),
        .dfe_signal_out(dfe_signal_out), .dfe_signal_out_valid(dfe_signal_out_valid),
        .out_sym(out_sym), .out_sym_valid(out_sym_valid), .state(state),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    // DFE model: decision = input ^ 8'h5A after 3 cycles; one chosen result can be dropped
    int         dfe_in_cnt = 0;
    int         drop_idx;
    logic [7:0] pd [3];
    logic       pv [3];
    always @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 3; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= dfe_signal_in_valid && (dfe_in_cnt != drop_idx);
            pd[0] <= dfe_signal_in ^ 8'h5A;
            pv[1] <= pv[0]; pd[1] <= pd[0];
            pv[2] <= pv[1]; pd[2] <= pd[1];
            if (dfe_signal_in_valid) dfe_in_cnt <= dfe_in_cnt + 1;
        end
    end
    assign dfe_signal_out_valid = pv[2];
    assign dfe_signal_out       = pd[2];

    typedef struct packed {
        logic [7:0] sig;
        logic [7:0] noise;
        logic       tv;
        logic [7:0] trn;
    } in_t;

    in_t        exp_in_q[$];
    logic [7:0] exp_out_q[$];
    logic [7:0] ch_q[$], ref_q[$];
    int n_checks = 0, n_errors = 0;
    int done_cnt = 0, err_cnt = 0, train_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        in_t        e;
        logic [7:0] o;
        forever begin
            @(negedge clk_clk);
            if (reset_reset_n) begin
                if (dfe_signal_in_valid) begin
                    if (exp_in_q.size() == 0) chk("dfe_in_unexpected", 1, 0);
                    else begin
                        e = exp_in_q.pop_front();
                        chk("dfe_signal_in", 32'(dfe_signal_in), 32'(e.sig));
                        chk("dfe_noise", 32'(dfe_noise), 32'(e.noise));
                        chk("dfe_train_valid", 32'(dfe_train_data_valid), 32'(e.tv));
                        if (e.tv) chk("dfe_train_data", 32'(dfe_train_data), 32'(e.trn));
                    end
                end else if (dfe_train_data_valid) begin
                    chk("train_valid_alone", 1, 0);
                end
                if (out_sym_valid) begin
                    if (exp_out_q.size() == 0) chk("out_sym_unexpected", 1, 0);
                    else begin
                        o = exp_out_q.pop_front();
                        chk("out_sym", 32'(out_sym), 32'(o));
                    end
                end
                if (done) done_cnt++;
                if (err_timeout) err_cnt++;
                if (state == 3'd2) train_seen++;
            end
        end
    endtask

    // Expected DFE input: FLUSH zeros, then every channel symbol in order; payload = data part
    task automatic prep(input int tl, input int nch, input bit drop_last);
        logic [7:0] c, r;
        ch_q.delete(); ref_q.delete();
        for (int i = 0; i < FLUSH; i++) exp_in_q.push_back('0);
        for (int i = 0; i < nch; i++) begin
            c = 8'($urandom);
            ch_q.push_back(c);
            if (i < tl) begin
                r = 8'($urandom);
                ref_q.push_back(r);
                exp_in_q.push_back({c, c ^ 8'hC3, 1'b1, r});
            end else begin
                exp_in_q.push_back({c, c ^ 8'hC3, 1'b0, 8'h00});
                if (!(drop_last && i == nch - 1)) exp_out_q.push_back(c ^ 8'h5A);
            end
        end
        drop_idx = drop_last ? dfe_in_cnt + FLUSH + nch - 1 : -1;
    endtask

    task automatic pulse_start();
        @(posedge clk_clk); #1 start = 1'b1;
        @(posedge clk_clk); #1 start = 1'b0;
    endtask

    task automatic feed(input int max_cyc, input int stall_at, input int restart_at,
                        output bit ok);
        int ci = 0, ri = 0, stall_n = 0;
        bit cf, rf, stall;
        ok = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            stall         = (stall_at >= 0) && (ri == stall_at) && (stall_n < 5);
            start         = (cyc == restart_at);
            ch_sym_valid  = (ci < ch_q.size()) && (stall || $urandom_range(3) != 0);
            ch_sym        = (ci < ch_q.size()) ? ch_q[ci] : 8'h00;
            noise_in      = ch_sym ^ 8'hC3;
            ref_sym_valid = !stall && (ri < ref_q.size()) && ($urandom_range(3) != 0);
            ref_sym       = (ri < ref_q.size()) ? ref_q[ri] : 8'h00;
            @(negedge clk_clk);
            cf = ch_sym_valid && ch_sym_ready;
            rf = ref_sym_valid && ref_sym_ready;
            if (stall) begin
                chk("t2_state", 32'(state), 2);
                chk("t2_ch_ready", 32'(ch_sym_ready), 0);
                chk("t2_ref_ready", 32'(ref_sym_ready), 0);
                if (stall_n > 0) chk("t2_no_issue", 32'(dfe_signal_in_valid), 0);
                stall_n++;
            end
            @(posedge clk_clk); #1;
            ci += int'(cf);
            ri += int'(rf);
            if (ci == ch_q.size() && ri == ref_q.size()) begin
                ok = 1'b1;
                break;
            end
        end
        ch_sym_valid = 1'b0; ref_sym_valid = 1'b0; start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_sig_valid"}, 32'(dfe_signal_in_valid), 0);
        chk({tag, "_sig"}, 32'(dfe_signal_in), 0);
        chk({tag, "_noise"}, 32'(dfe_noise), 0);
        chk({tag, "_trn_valid"}, 32'(dfe_train_data_valid), 0);
        chk({tag, "_out_valid"}, 32'(out_sym_valid), 0);
        chk({tag, "_ch_ready"}, 32'(ch_sym_ready), 0);
        chk({tag, "_ref_ready"}, 32'(ref_sym_ready), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    task automatic do_run(input string tag, input int tl, input int dl, input bit drop,
                          input int stall_at, input int restart_at);
        bit ok, got_done, got_err;
        int d0, e0, drain_cyc;
        train_len = 16'(tl);
        data_len  = 16'(dl);
        prep(tl, tl + dl, drop);
        d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        feed(4000, stall_at, restart_at, ok);
        chk({tag, "_feed_complete"}, 32'(ok), 1);
        got_done = 1'b0; got_err = 1'b0; drain_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_clk);
            if (state == 3'd4) drain_cyc++;
            if (done || err_timeout) begin
                got_done = done; got_err = err_timeout;
                chk({tag, "_end_state"}, 32'(state), 0);
                break;
            end
        end
        chk({tag, "_done"}, 32'(got_done), 32'(!drop));
        chk({tag, "_err"}, 32'(got_err), 32'(drop));
        if (drop) chk({tag, "_drain_cycles"}, 32'(drain_cyc), 32'(DTO));
        repeat (6) @(negedge clk_clk);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(!drop));
        chk({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'(drop));
        chk({tag, "_in_left"}, 32'(exp_in_q.size()), 0);
        chk({tag, "_out_left"}, 32'(exp_out_q.size()), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        exp_in_q.delete(); exp_out_q.delete();
    endtask

    initial begin
        bit ok;
        int d0, t0;
        fork monitor(); join_none
        drop_idx = -1;
        reset_reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        train_len = '0; data_len = '0;
        ch_sym = '0; ref_sym = '0; noise_in = '0;
        ch_sym_valid = 1'b1; ref_sym_valid = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        check_idle("reset");
        ch_sym_valid = 1'b0; ref_sym_valid = 1'b0;

        do_run("t1", 4, 6, 1'b0, -1, -1);
        do_run("t2", 8, 4, 1'b0, 2, -1);

        t0 = train_seen;
        do_run("t6", 0, 5, 1'b0, -1, 10);
        chk("t6_no_train", 32'(train_seen - t0), 0);

        for (int r = 0; r < 4; r++)
            do_run("rnd", int'($urandom_range(6)), int'($urandom_range(10, 1)), 1'b0, -1, -1);

        do_run("t4", 3, 5, 1'b1, -1, -1);

        // Unlimited payload, then abort
        train_len = 16'd3; data_len = 16'd0;
        prep(3, 1003, 1'b0);
        d0 = done_cnt;
        pulse_start();
        feed(6000, -1, -1, ok);
        chk("t3_feed_complete", 32'(ok), 1);
        repeat (10) @(negedge clk_clk);
        chk("t3_still_data", 32'(state), 3);
        chk("t3_out_left", 32'(exp_out_q.size()), 0);
        chk("t3_in_left", 32'(exp_in_q.size()), 0);
        @(posedge clk_clk); #1 abort = 1'b1;
        ch_sym_valid = 1'b1; ref_sym_valid = 1'b1;
        @(posedge clk_clk); #1 abort = 1'b0;
        check_idle("t3_abort");
        ch_sym_valid = 1'b0; ref_sym_valid = 1'b0;
        repeat (5) @(negedge clk_clk);
        chk("t3_no_done", 32'(done_cnt - d0), 0);

        // Reset in the middle of training, then a normal run
        train_len = 16'd20; data_len = 16'd5;
        prep(20, 25, 1'b0);
        pulse_start();
        feed(16, -1, -1, ok);
        @(negedge clk_clk);
        chk("t5_in_train", 32'(state), 2);
        @(posedge clk_clk); #1 reset_reset_n = 1'b0;
        ch_sym_valid = 1'b1; ref_sym_valid = 1'b1;
        @(posedge clk_clk); #1 reset_reset_n = 1'b1;
        check_idle("t5_reset");
        ch_sym_valid = 1'b0; ref_sym_valid = 1'b0;
        exp_in_q.delete(); exp_out_q.delete();
        repeat (6) @(posedge clk_clk);
        do_run("t5_rerun", 5, 7, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
